ctrl_pipe: RTL
==============

Name: ctrl_pipe

Overview:
- Consumer of the 8-bit ID-stage control word; the other end of the decoder interface.
- Carries the control word and destination register through the ID/EX, EX/MEM and MEM/WB boundaries of the 5-stage MIPS pipeline.
- Unpacks the control word into per-stage control outputs.
- Detects load-use hazards and inserts bubbles.
- Handles branch flush.

Parameters:
- CTRL_W, 8: width of the ID control word. Bit map: [7] RegWrite, [6] MemtoReg, [5] MemRead, [4] MemWrite, [3] ALUSrc, [2:1] ALUOp, [0] RegDst.
- REG_AW, 5: register-address width.
- CNT_W, 16: width of the performance counters (optional feature only).

Ports:
- clk_i  in  1  pipeline clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- ctrl_i  in  CTRL_W  control word of the instruction currently in ID.
- id_rs_i  in  REG_AW  rs field of the ID instruction.
- id_rt_i  in  REG_AW  rt field of the ID instruction.
- id_rd_i  in  REG_AW  rd field of the ID instruction.
- flush_i  in  1  branch taken in ID; squash the ID instruction.
- stall_o  out  1  hold PC and IF/ID this cycle.
- ex_alusrc_o  out  1  EX-stage ALUSrc.
- ex_aluop_o  out  2  EX-stage ALUOp.
- ex_rs_o  out  REG_AW  EX-stage rs, for forwarding.
- ex_rt_o  out  REG_AW  EX-stage rt, for forwarding.
- ex_wreg_o  out  REG_AW  EX destination: RegDst ? rd : rt.
- mem_read_o  out  1  MEM-stage MemRead.
- mem_write_o  out  1  MEM-stage MemWrite.
- mem_regwrite_o  out  1  MEM-stage RegWrite, for forwarding.
- mem_wreg_o  out  REG_AW  MEM-stage destination register.
- wb_regwrite_o  out  1  WB-stage RegWrite.
- wb_memtoreg_o  out  1  WB-stage MemtoReg.
- wb_wreg_o  out  REG_AW  WB-stage destination register.

Behaviour:
- Reset: rst_i low asynchronously clears every stage register (control, rs, rt, rd, wreg) to 0. All outputs read 0, stall_o is 0, and the pipeline holds bubbles.
- Reset mid-operation discards all in-flight state. The first post-reset edge loads ctrl_i normally.
- Latency: a control word presented in ID in cycle N appears on the EX outputs in N+1, the MEM outputs in N+2 and the WB outputs in N+3. The pipeline has no backpressure beyond the bubble mechanism.
- Hazard, combinational: hazard = ex_MemRead & (ex_rt != 0) & (ex_rt == id_rs_i | ex_rt == id_rt_i).
- stall_o = hazard & ~flush_i.
- EX stage load on each edge:
  - if hazard or flush_i, load all-zero control (bubble) and rs/rt/rd = 0;
  - otherwise load ctrl_i, id_rs_i, id_rt_i and id_rd_i.
- Hazard and flush_i together: bubble inserted, stall_o = 0. The squashed ID instruction needs no retry.
- The MEM and WB stages always advance; a stall never freezes them.
- MEM stage loads RegWrite, MemtoReg, MemRead, MemWrite and ex_wreg.
- RegWrite is forced to 0 on MEM entry when ex_wreg == 0 (no writes to $zero).
- WB stage loads RegWrite, MemtoReg and the wreg from the MEM stage.
- Undefined opcodes arrive as an all-zero control word and behave as bubbles.
- The hazard is a single-cycle stall. After the bubble, the EX stage holds no load, so the hazard deasserts and the stalled instruction enters.

Optional Feature:
- Macro: CTRL_PIPE_PERF_EN.
- When defined, the block adds outputs stall_cnt_o [CNT_W] and flush_cnt_o [CNT_W].
  - Each counts the cycles in which stall_o or flush_i was high, respectively.
  - Both are reset to 0 by rst_i.
  - Both saturate at all-ones and do not wrap.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package ctrl_pkg holds:
  - CTRL_W and the bit-index constants CTRL_REGWRITE=7, CTRL_MEMTOREG=6, CTRL_MEMREAD=5, CTRL_MEMWRITE=4, CTRL_ALUSRC=3, CTRL_ALUOP_HI=2, CTRL_ALUOP_LO=1, CTRL_REGDST=0;
  - the ALUOp encodings;
  - the OP_RTYPE/OP_LW/OP_SW/OP_BEQ/OP_ADDI/OP_J opcode constants, shared with the decoder.
- One natural sub-module: hazard_unit, the combinational load-use compare producing hazard.
- The stage registers stay in ctrl_pipe.

Test Plan:
1. Reset then R-type: ctrl_i=8'b10000101, rs=1, rt=2, rd=3.
   - EX next cycle: aluop=2'b10, wreg=3.
   - MEM: regwrite=1, wreg=3.
   - WB: regwrite=1, memtoreg=0, wreg=3.
2. Load-use: lw (8'b11101000, rt=5), then R-type with rs=5.
   - stall_o=1 for exactly 1 cycle; EX shows a bubble (all 0).
   - The R-type reaches EX one cycle later.
3. Load-use with rt=0: lw with rt=0, then rs=0.
   - stall_o stays 0.
   - mem_regwrite_o=0 when the lw reaches MEM.
4. Flush: flush_i=1 with ctrl_i=swInfo (8'b00011000).
   - Next cycle all EX outputs are 0; mem_write_o stays 0 two cycles later.
5. Hazard and flush together: lw in EX with rt=4; ID has rs=4 and flush_i=1.
   - stall_o=0 and a bubble is inserted.
6. Asynchronous reset with lw/sw in flight: rst_i low mid-cycle.
   - All outputs go to 0 before the next edge.
   - If CTRL_PIPE_PERF_EN is defined, both counters read 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the ID-stage control word: bit positions, ALUOp
// encodings and the opcode constants the decoder and ctrl_pipe agree on.
package ctrl_pkg;

  // Control word layout
  localparam int CTRL_W        = 8;
  localparam int CTRL_REGWRITE = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_MEMREAD  = 5;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_ALUSRC   = 3;
  localparam int CTRL_ALUOP_HI = 2;
  localparam int CTRL_ALUOP_LO = 1;
  localparam int CTRL_REGDST   = 0;

  // Width of the optional stall/flush performance counters
  localparam int CNT_W = 16;

  // ALUOp encodings carried in control bits [2:1]
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,  // lw/sw/addi address or immediate add
    ALUOP_SUB   = 2'b01,  // beq compare
    ALUOP_FUNCT = 2'b10,  // R-type, ALU op taken from funct field
    ALUOP_RSVD  = 2'b11
  } aluop_e;

  // Primary opcodes shared with the decoder
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/ctrl_pipe_hazard_unit.sv
// Load-use hazard detection: a load sitting in EX whose destination (rt)
// is a source of the instruction in ID forces a one-cycle bubble.
// Register $zero never creates a dependency.
module hazard_unit
  import ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              hazard
);

  // Purely combinational compare against both ID source fields
  assign hazard = ex_memread && (ex_rt != '0) &&
                  ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries the ID control word and destination register through
// the ID/EX, EX/MEM and MEM/WB boundaries, inserts load-use bubbles and
// squashes the ID instruction on a taken branch.
// Optional macro CTRL_PIPE_PERF_EN adds saturating stall/flush counters.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              ex_alusrc_o,
  output logic [1:0]        ex_aluop_o,
  output logic [REG_AW-1:0] ex_rs_o,
  output logic [REG_AW-1:0] ex_rt_o,
  output logic [REG_AW-1:0] ex_wreg_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic              mem_regwrite_o,
  output logic [REG_AW-1:0] mem_wreg_o,
  output logic              wb_regwrite_o,
  output logic              wb_memtoreg_o,
  output logic [REG_AW-1:0] wb_wreg_o
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

  // ID/EX stage registers
  logic [CTRL_W-1:0] ex_ctrl_reg;
  logic [REG_AW-1:0] ex_rs_reg;
  logic [REG_AW-1:0] ex_rt_reg;
  logic [REG_AW-1:0] ex_rd_reg;

  // EX/MEM stage registers
  logic              mem_regwrite_reg;
  logic              mem_memtoreg_reg;
  logic              mem_read_reg;
  logic              mem_write_reg;
  logic [REG_AW-1:0] mem_wreg_reg;

  // MEM/WB stage registers
  logic              wb_regwrite_reg;
  logic              wb_memtoreg_reg;
  logic [REG_AW-1:0] wb_wreg_reg;

  logic              hazard;
  logic              bubble;
  logic [REG_AW-1:0] ex_wreg;

  hazard_unit #(
    .REG_AW (REG_AW)
  ) u_hazard (
    .ex_memread (ex_ctrl_reg[CTRL_MEMREAD]),
    .ex_rt      (ex_rt_reg),
    .id_rs      (id_rs_i),
    .id_rt      (id_rt_i),
    .hazard     (hazard)
  );

  // A flush already squashes the ID instruction, so it never needs holding
  assign bubble  = hazard | flush_i;
  assign stall_o = hazard & ~flush_i;

  // Destination register is resolved in EX from RegDst
  assign ex_wreg = ex_ctrl_reg[CTRL_REGDST] ? ex_rd_reg : ex_rt_reg;

  // ID/EX: load the ID instruction, or an all-zero bubble on hazard/flush
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_ctrl_reg <= '0;
      ex_rs_reg   <= '0;
      ex_rt_reg   <= '0;
      ex_rd_reg   <= '0;
    end else if (bubble) begin
      ex_ctrl_reg <= '0;
      ex_rs_reg   <= '0;
      ex_rt_reg   <= '0;
      ex_rd_reg   <= '0;
    end else begin
      ex_ctrl_reg <= ctrl_i;
      ex_rs_reg   <= id_rs_i;
      ex_rt_reg   <= id_rt_i;
      ex_rd_reg   <= id_rd_i;
    end
  end

  // EX/MEM: always advances; writes to $zero are dropped here
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_regwrite_reg <= 1'b0;
      mem_memtoreg_reg <= 1'b0;
      mem_read_reg     <= 1'b0;
      mem_write_reg    <= 1'b0;
      mem_wreg_reg     <= '0;
    end else begin
      mem_regwrite_reg <= ex_ctrl_reg[CTRL_REGWRITE] && (ex_wreg != '0);
      mem_memtoreg_reg <= ex_ctrl_reg[CTRL_MEMTOREG];
      mem_read_reg     <= ex_ctrl_reg[CTRL_MEMREAD];
      mem_write_reg    <= ex_ctrl_reg[CTRL_MEMWRITE];
      mem_wreg_reg     <= ex_wreg;
    end
  end

  // MEM/WB: always advances
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wb_regwrite_reg <= 1'b0;
      wb_memtoreg_reg <= 1'b0;
      wb_wreg_reg     <= '0;
    end else begin
      wb_regwrite_reg <= mem_regwrite_reg;
      wb_memtoreg_reg <= mem_memtoreg_reg;
      wb_wreg_reg     <= mem_wreg_reg;
    end
  end

  assign ex_alusrc_o    = ex_ctrl_reg[CTRL_ALUSRC];
  assign ex_aluop_o     = ex_ctrl_reg[CTRL_ALUOP_HI:CTRL_ALUOP_LO];
  assign ex_rs_o        = ex_rs_reg;
  assign ex_rt_o        = ex_rt_reg;
  assign ex_wreg_o      = ex_wreg;
  assign mem_read_o     = mem_read_reg;
  assign mem_write_o    = mem_write_reg;
  assign mem_regwrite_o = mem_regwrite_reg;
  assign mem_wreg_o     = mem_wreg_reg;
  assign wb_regwrite_o  = wb_regwrite_reg;
  assign wb_memtoreg_o  = wb_memtoreg_reg;
  assign wb_wreg_o      = wb_wreg_reg;

`ifdef CTRL_PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  // Saturating event counters: stop at all-ones instead of wrapping
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall_o && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
      if (flush_i && (flush_cnt_reg != '1)) begin
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_reg;
  assign flush_cnt_o = flush_cnt_reg;
`else
  // Counters are not built in this configuration
`endif

endmodule
